// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring divide
// on operand magnitudes, followed by a sign-fix cycle and a one-cycle writeback pulse.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADD_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] opA,
   input  logic [DATA_WIDTH-1:0] opB,
   input  logic [ADD_WIDTH-1:0]  rd,
   output logic                  busy,
   output logic                  done,
   output logic                  we,
   output logic [ADD_WIDTH-1:0]  rd_out,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state_reg, state_next;
   logic [2:0]         op_reg;
   logic [ADD_WIDTH-1:0] rd_reg;
   logic               sign_a_reg, sign_b_reg;
   logic [W-1:0]       mag_a_reg, mag_b_reg;
   logic [2*W-1:0]     prod_reg;
   logic [W:0]         rem_reg;
   logic [W-1:0]       quo_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [W-1:0]       result_reg;

   // Operand decode at capture time
   logic         is_div_in, signed_a_in, signed_b_in, sign_a_in, sign_b_in;
   logic [W-1:0] mag_a_in, mag_b_in;

   always_comb begin
      is_div_in   = funct3[2];
      signed_a_in = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
      signed_b_in = is_div_in ? ~funct3[0] : ~funct3[1];
      sign_a_in   = signed_a_in & opA[W-1];
      sign_b_in   = signed_b_in & opB[W-1];
      mag_a_in    = sign_a_in ? (~opA + 1'b1) : opA;
      mag_b_in    = sign_b_in ? (~opB + 1'b1) : opB;
   end

   // One iteration of each datapath; both advance in CALC, only the relevant one is used.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_shift, div_diff;
   logic           div_ge;

   always_comb begin
      mul_sum   = {1'b0, prod_reg[2*W-1:W]} + (prod_reg[0] ? {1'b0, mag_a_reg} : '0);
      mul_next  = {mul_sum, prod_reg[W-1:1]};
      div_shift = {rem_reg[W-1:0], quo_reg[W-1]};
      div_ge    = (div_shift >= {1'b0, mag_b_reg});
      div_diff  = div_shift - {1'b0, mag_b_reg};
   end

   // Sign correction and result selection
   logic           neg_res, div_zero;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix, a_orig, fix_value;

   always_comb begin
      neg_res  = sign_a_reg ^ sign_b_reg;
      div_zero = (mag_b_reg == '0);
      prod_fix = neg_res ? (~prod_reg + 1'b1) : prod_reg;
      quo_fix  = neg_res ? (~quo_reg + 1'b1) : quo_reg;
      rem_fix  = sign_a_reg ? (~rem_reg[W-1:0] + 1'b1) : rem_reg[W-1:0];
      a_orig   = sign_a_reg ? (~mag_a_reg + 1'b1) : mag_a_reg;
      fix_value = '0;
      case (op_reg)
         3'b000:                 fix_value = prod_fix[W-1:0];
         3'b001, 3'b010, 3'b011: fix_value = prod_fix[2*W-1:W];
         3'b100, 3'b101:         fix_value = div_zero ? '1 : quo_fix;
         default:                fix_value = div_zero ? a_orig : rem_fix;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = CALC;
         CALC: if (cnt_reg == CNT_W'(W - 1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         op_reg     <= '0;
         rd_reg     <= '0;
         sign_a_reg <= 1'b0;
         sign_b_reg <= 1'b0;
         mag_a_reg  <= '0;
         mag_b_reg  <= '0;
         prod_reg   <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (start) begin
               op_reg     <= funct3;
               rd_reg     <= rd;
               sign_a_reg <= sign_a_in;
               sign_b_reg <= sign_b_in;
               mag_a_reg  <= mag_a_in;
               mag_b_reg  <= mag_b_in;
               prod_reg   <= {{W{1'b0}}, mag_b_in};
               quo_reg    <= mag_a_in;
               rem_reg    <= '0;
               cnt_reg    <= '0;
            end
            CALC: begin
               prod_reg <= mul_next;
               rem_reg  <= div_ge ? div_diff : div_shift;
               quo_reg  <= {quo_reg[W-2:0], div_ge};
               cnt_reg  <= cnt_reg + 1'b1;
            end
            FIX: result_reg <= fix_value;
            default: ;
         endcase
      end
   end

   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == DONE);
   assign we     = done;
   assign rd_out = rd_reg;
   assign result = result_reg;

endmodule
